// File: rtl/uart_tx_arb.sv
// Message-granular round-robin arbiter that shares one UART transmitter between NREQ byte streams,
// with an optional channel-ID header byte and an optional idle gap after each message.
module uart_tx_arb #(
  parameter int NREQ     = 4,
  parameter int N        = 8,
  parameter int HDR_EN   = 1,
  parameter int HDR_BASE = 'h30,
  parameter int GAP      = 16,
  parameter int TIMEOUT  = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ*N-1:0] req_data,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [NREQ-1:0]   req_last,
  output logic [NREQ-1:0]   req_ready,
  output logic [N-1:0]      tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic [NREQ-1:0]   grant,
  output logic              busy,
  output logic              abort,
  output logic [1:0]        state_dbg
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int GW = $clog2(GAP + 2);
  localparam int TW = $clog2(TIMEOUT + 2);

  // Handshake: a byte moves when valid & ready are both high in the same cycle; a source never
  // drops valid without a transfer, except on abort or reset.
  typedef enum logic [1:0] {S_IDLE, S_HDR, S_BODY, S_GAP} state_t;

  state_t        state, state_nxt;
  logic [IW-1:0] g_idx, g_idx_nxt;
  logic [IW-1:0] ptr, ptr_nxt;
  logic [GW-1:0] gap_cnt, gap_cnt_nxt;
  logic [TW-1:0] to_cnt, to_cnt_nxt;
  logic          arb_found;
  logic [IW-1:0] arb_idx;
  logic [IW-1:0] cand;

  // Rotating-priority scan starting just after the last served requester.
  always_comb begin
    arb_found = 1'b0;
    arb_idx   = '0;
    cand      = '0;
    for (int k = 1; k <= NREQ; k++) begin
      cand = IW'((int'(ptr) + k) % NREQ);
      if (!arb_found && req_valid[cand]) begin
        arb_found = 1'b1;
        arb_idx   = cand;
      end
    end
  end

  always_comb begin
    state_nxt   = state;
    g_idx_nxt   = g_idx;
    ptr_nxt     = ptr;
    gap_cnt_nxt = gap_cnt;
    to_cnt_nxt  = to_cnt;
    tx_data     = '0;
    tx_valid    = 1'b0;
    req_ready   = '0;
    abort       = 1'b0;
    case (state)
      S_IDLE: begin
        if (arb_found) begin
          g_idx_nxt  = arb_idx;
          to_cnt_nxt = '0;
          state_nxt  = (HDR_EN != 0) ? S_HDR : S_BODY;
        end
      end
      S_HDR: begin
        tx_data  = N'(HDR_BASE + int'(g_idx));
        tx_valid = 1'b1;
        if (tx_ready) state_nxt = S_BODY;
      end
      S_BODY: begin
        tx_data          = req_data[int'(g_idx)*N +: N];
        tx_valid         = req_valid[g_idx];
        req_ready[g_idx] = tx_ready;
        if (tx_valid && tx_ready) begin
          to_cnt_nxt = '0;
          if (req_last[g_idx]) begin
            ptr_nxt     = g_idx;
            gap_cnt_nxt = '0;
            state_nxt   = (GAP > 0) ? S_GAP : S_IDLE;
          end
        end else if (TIMEOUT > 0) begin
          // A stalled UART counts too, so a wedged transmitter cannot hold the link forever.
          if (to_cnt == TW'(TIMEOUT - 1)) begin
            abort       = 1'b1;
            ptr_nxt     = g_idx;
            gap_cnt_nxt = '0;
            to_cnt_nxt  = '0;
            state_nxt   = (GAP > 0) ? S_GAP : S_IDLE;
          end else begin
            to_cnt_nxt = to_cnt + TW'(1);
          end
        end
      end
      S_GAP: begin
        if (gap_cnt == GW'(GAP - 1)) state_nxt = S_IDLE;
        else gap_cnt_nxt = gap_cnt + GW'(1);
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= S_IDLE;
      g_idx   <= '0;
      ptr     <= IW'(NREQ - 1);
      gap_cnt <= '0;
      to_cnt  <= '0;
    end else begin
      state   <= state_nxt;
      g_idx   <= g_idx_nxt;
      ptr     <= ptr_nxt;
      gap_cnt <= gap_cnt_nxt;
      to_cnt  <= to_cnt_nxt;
    end
  end

  // Grant is decoded from state so it clears together with tx_valid/req_ready.
  always_comb begin
    grant = '0;
    if (state == S_HDR || state == S_BODY) grant[g_idx] = 1'b1;
  end

  assign busy      = (state != S_IDLE);
  assign state_dbg = state;

endmodule

// File: tb/tb_uart_tx_arb.sv
// Directed bench for uart_tx_arb: one instance without gap/timeout, one with GAP=16, TIMEOUT=100.
module tb_uart_tx_arb;

  logic        clk;
  logic        rst;
  logic [31:0] req_data;
  logic [3:0]  req_valid;
  logic [3:0]  req_last;
  logic        tx_ready;

  logic [3:0]  req_ready_a, grant_a, req_ready_b, grant_b;
  logic [7:0]  tx_data_a, tx_data_b;
  logic        tx_valid_a, busy_a, abort_a, tx_valid_b, busy_b, abort_b;
  logic [1:0]  state_dbg_a, state_dbg_b;

  int total = 0;
  int bad   = 0;
  int n, m;
  logic seen3;

  uart_tx_arb #(.NREQ(4), .N(8), .HDR_EN(1), .HDR_BASE('h30), .GAP(0), .TIMEOUT(0)) dut_a (
    .clk(clk), .rst(rst), .req_data(req_data), .req_valid(req_valid), .req_last(req_last),
    .req_ready(req_ready_a), .tx_data(tx_data_a), .tx_valid(tx_valid_a), .tx_ready(tx_ready),
    .grant(grant_a), .busy(busy_a), .abort(abort_a), .state_dbg(state_dbg_a)
  );

  uart_tx_arb #(.NREQ(4), .N(8), .HDR_EN(1), .HDR_BASE('h30), .GAP(16), .TIMEOUT(100)) dut_b (
    .clk(clk), .rst(rst), .req_data(req_data), .req_valid(req_valid), .req_last(req_last),
    .req_ready(req_ready_b), .tx_data(tx_data_b), .tx_valid(tx_valid_b), .tx_ready(tx_ready),
    .grant(grant_b), .busy(busy_b), .abort(abort_b), .state_dbg(state_dbg_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset;
    rst = 1'b0;
    req_valid = '0;
    req_last  = '0;
    req_data  = '0;
    tx_ready  = 1'b0;
    tick;
    tick;
    rst = 1'b1;
  endtask

  // UART stand-in on dut_a: busy one cycle, then ready for one cycle to take the byte.
  task automatic uart_a(input logic [7:0] exp_d, input logic [3:0] exp_rr, input string tag);
    tx_ready = 1'b0;
    #1;
    chk({tag, "_valid"}, 32'(tx_valid_a), 32'h1);
    chk({tag, "_data"},  32'(tx_data_a),  32'(exp_d));
    chk({tag, "_rr_busy"}, 32'(req_ready_a), 32'h0);
    tick;
    tx_ready = 1'b1;
    #1;
    chk({tag, "_rr"},    32'(req_ready_a), 32'(exp_rr));
    chk({tag, "_data2"}, 32'(tx_data_a),   32'(exp_d));
    tick;
    tx_ready = 1'b0;
  endtask

  int exp_idx[5] = '{0, 1, 2, 3, 0};

  initial begin
    // Reset values while rst is held low.
    rst = 1'b0;
    req_valid = '0;
    req_last  = '0;
    req_data  = '0;
    tx_ready  = 1'b0;
    tick;
    tick;
    chk("rst_grant",    32'(grant_a),     32'h0);
    chk("rst_tx_valid", 32'(tx_valid_a),  32'h0);
    chk("rst_req_ready",32'(req_ready_a), 32'h0);
    chk("rst_busy",     32'(busy_a),      32'h0);
    chk("rst_state",    32'(state_dbg_a), 32'h0);
    chk("rst_abort",    32'(abort_b),     32'h0);
    rst = 1'b1;

    // Single message from requester 2: header '2' then 'A','B','C'.
    req_data[23:16] = 8'h41;
    req_valid = 4'b0100;
    tick;
    chk("t1_grant", 32'(grant_a), 32'h4);
    chk("t1_busy",  32'(busy_a),  32'h1);
    uart_a(8'h32, 4'b0000, "t1_hdr");
    uart_a(8'h41, 4'b0100, "t1_a");
    chk("t1_grant_body", 32'(grant_a), 32'h4);
    req_data[23:16] = 8'h42;
    uart_a(8'h42, 4'b0100, "t1_b");
    req_data[23:16] = 8'h43;
    req_last = 4'b0100;
    uart_a(8'h43, 4'b0100, "t1_c");
    req_valid = '0;
    req_last  = '0;
    #1;
    chk("t1_busy_end",  32'(busy_a),     32'h0);
    chk("t1_grant_end", 32'(grant_a),    32'h0);
    chk("t1_txv_end",   32'(tx_valid_a), 32'h0);

    // Round robin: all four requesters always valid with 1-byte messages.
    do_reset;
    req_data  = 32'h63626160;
    req_valid = 4'hf;
    req_last  = 4'hf;
    tx_ready  = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick;
      chk("t2_grant", 32'(grant_a),   32'(1 << exp_idx[k]));
      chk("t2_hdr",   32'(tx_data_a), 32'h30 + 32'(exp_idx[k]));
      tick;
      chk("t2_body",  32'(tx_data_a),   32'h60 + 32'(exp_idx[k]));
      chk("t2_rr",    32'(req_ready_a), 32'(1 << exp_idx[k]));
      tick;
      chk("t2_idle",  32'(busy_a), 32'h0);
    end

    // Message lock: requester 1 valid throughout while requester 0 sends 4 bytes.
    do_reset;
    req_data[15:8] = 8'h55;
    req_data[7:0]  = 8'h10;
    req_valid = 4'b0011;
    req_last  = 4'b0010;
    tx_ready  = 1'b1;
    tick;
    chk("t3_grant_hdr", 32'(grant_a),   32'h1);
    chk("t3_hdr",       32'(tx_data_a), 32'h30);
    tick;
    for (int k = 0; k < 4; k++) begin
      req_data[7:0] = 8'h10 + 8'(k);
      req_last[0]   = (k == 3);
      #1;
      chk("t3_data",  32'(tx_data_a),   32'h10 + 32'(k));
      chk("t3_rr",    32'(req_ready_a), 32'h1);
      chk("t3_grant", 32'(grant_a),     32'h1);
      tick;
    end
    req_valid[0] = 1'b0;
    #1;
    chk("t3_idle_txv", 32'(tx_valid_a), 32'h0);
    tick;
    chk("t3_grant1", 32'(grant_a),   32'h2);
    chk("t3_hdr1",   32'(tx_data_a), 32'h31);

    // Gap on dut_b: two back-to-back 1-byte messages.
    do_reset;
    req_data  = 32'h00002010;
    req_valid = 4'b0011;
    req_last  = 4'b0011;
    tx_ready  = 1'b1;
    tick;
    chk("t4_grant0", 32'(grant_b),   32'h1);
    chk("t4_hdr0",   32'(tx_data_b), 32'h30);
    tick;
    chk("t4_body0",  32'(tx_data_b), 32'h10);
    tick;
    req_valid = 4'b0010;
    #1;
    chk("t4_gap_grant", 32'(grant_b),    32'h0);
    chk("t4_gap_busy",  32'(busy_b),     32'h1);
    chk("t4_gap_txv",   32'(tx_valid_b), 32'h0);
    n = 0;
    while (tx_valid_b !== 1'b1 && n < 40) begin
      n++;
      tick;
    end
    chk("t4_gap_len", 32'(n),         32'd17);
    chk("t4_hdr1",    32'(tx_data_b), 32'h31);
    chk("t4_grant1",  32'(grant_b),   32'h2);

    // Timeout on dut_b: requester 3 sends one byte without last, then goes quiet.
    do_reset;
    req_data[31:24] = 8'h77;
    req_valid = 4'b1000;
    tx_ready  = 1'b1;
    tick;
    chk("t5_grant", 32'(grant_b),   32'h8);
    chk("t5_hdr",   32'(tx_data_b), 32'h33);
    tick;
    chk("t5_body",  32'(tx_data_b),   32'h77);
    chk("t5_rr",    32'(req_ready_b), 32'h8);
    tick;
    req_valid = 4'b0001;
    req_last  = 4'b0001;
    req_data[7:0] = 8'h44;
    #1;
    n = 1;
    while (abort_b !== 1'b1 && n < 200) begin
      tick;
      n++;
    end
    chk("t5_abort_time", 32'(n), 32'd100);
    tick;
    chk("t5_abort_pulse", 32'(abort_b), 32'h0);
    chk("t5_grant_clr",   32'(grant_b), 32'h0);
    seen3 = 1'b0;
    m = 0;
    while (grant_b === 4'b0000 && m < 40) begin
      if (req_ready_b[3]) seen3 = 1'b1;
      tick;
      m++;
    end
    chk("t5_next_grant", 32'(grant_b), 32'h1);
    chk("t5_wait",       32'(m),       32'd17);
    chk("t5_rr3_quiet",  32'(seen3),   32'h0);

    // Asynchronous reset in the middle of a message on dut_a.
    do_reset;
    req_data[15:8] = 8'h99;
    req_valid = 4'b0010;
    tx_ready  = 1'b1;
    tick;
    tick;
    chk("t6_txv",   32'(tx_valid_a),  32'h1);
    chk("t6_rr",    32'(req_ready_a), 32'h2);
    chk("t6_grant", 32'(grant_a),     32'h2);
    #2;
    rst = 1'b0;
    #1;
    chk("t6_rst_txv",   32'(tx_valid_a),  32'h0);
    chk("t6_rst_rr",    32'(req_ready_a), 32'h0);
    chk("t6_rst_grant", 32'(grant_a),     32'h0);
    req_valid = 4'b1010;
    tick;
    tick;
    rst = 1'b1;
    tick;
    chk("t6_first_grant", 32'(grant_a),   32'h2);
    chk("t6_first_hdr",   32'(tx_data_a), 32'h31);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_tx_arb.md
Name: uart_tx_arb

Overview:
- Round-robin arbiter that shares one UART transmitter between NREQ byte-stream requesters.
- Arbitration is at message granularity: a grant is held until the requester's byte flagged last is accepted.
- Optionally prefixes each message with a channel-ID header byte and enforces an idle gap between messages.
- Sits between on-chip message sources and the uart_tx valid/ready data input.

Parameters:
- NREQ, 4, number of requesters (2..8)
- N, 8, data width; must match the UART transmitter
- HDR_EN, 1, 1 = send header byte (HDR_BASE + grant index, mod 2^N) before each message
- HDR_BASE, 8'h30, header base value (ASCII '0')
- GAP, 16, idle clk cycles forced after each message; 0 = none
- TIMEOUT, 0, max clk cycles in BODY without a handshake before abort; 0 = disabled

Ports:
- clk  input  1  clock
- rst  input  1  asynchronous, active-low reset
- req_data  input  NREQ*N  requester i byte at [i*N +: N]
- req_valid  input  NREQ  requester byte valid
- req_last  input  NREQ  byte is last of message (sampled with req_valid)
- req_ready  output  NREQ  byte accepted when req_valid & req_ready
- tx_data  output  N  byte to UART transmitter
- tx_valid  output  1  byte valid to UART transmitter
- tx_ready  input  1  UART transmitter ready (high only while idle)
- grant  output  NREQ  one-hot current owner; 0 when no owner
- busy  output  1  state != IDLE
- abort  output  1  one-cycle pulse when a message is aborted by timeout

Behaviour:
- Reset (async, rst=0):
  - state=IDLE, grant=0, ptr=NREQ-1 (requester 0 has first priority).
  - tx_valid=0, req_ready=0, abort=0, gap/timeout counters=0.
  - tx_valid and req_ready are decoded from state, so they drop immediately on reset assertion, including mid-message.
- Handshake: transfer on valid & ready. tx_valid is never deasserted without a transfer except on abort or reset.
- IDLE:
  - If any req_valid, select the first valid index scanning ptr+1, ptr+2, ... mod NREQ.
  - Register grant; next state is HDR if HDR_EN, else BODY.
  - One-cycle arbitration latency; nothing is driven to tx in IDLE.
- HDR:
  - tx_data = HDR_BASE + index, tx_valid=1, req_ready=0.
  - On tx_ready: go to BODY.
  - The header is committed once granted, even if the requester drops valid.
- BODY:
  - Combinational pass-through: tx_data = req_data[g], tx_valid = req_valid[g], req_ready[g] = tx_ready, other req_ready=0.
  - On a handshake with req_last[g]=1: ptr <= g, then GAP if GAP>0, else IDLE.
- GAP:
  - tx_valid=0, all req_ready=0.
  - Count GAP cycles, then IDLE.
  - grant is cleared on entering GAP.
- Timeout (TIMEOUT>0):
  - Counter runs in BODY, resets on every handshake.
  - On reaching TIMEOUT: pulse abort for 1 cycle, ptr <= g, go to GAP (or IDLE if GAP=0). No byte is driven.
  - The counter runs only while tx_valid=0 or tx_ready=0; a byte stalled by a busy UART also counts.
- Fairness: after a requester completes or aborts, it has lowest priority at the next arbitration.
- Simultaneous requests: resolved in a single cycle by rotating priority. Requests arriving during HDR, BODY or GAP wait.
- A requester holding valid with no last byte owns the link indefinitely when TIMEOUT=0.
- req_last on a non-granted requester is ignored.

Test Plan:
- Single message, HDR_EN=1, GAP=0: req 2 sends 3 bytes 'A','B','C' (last on 'C') with tx_ready pulsing as from uart_tx.
  - Required: tx bytes 0x32,0x41,0x42,0x43.
  - busy drops the cycle after 'C' is accepted; grant=0100 during the message.
- Round-robin: all 4 requesters send 1-byte messages continuously from reset.
  - Required: grant order 0,1,2,3,0.
  - Requester 1 re-requesting immediately is served only after 2 and 3.
- Message lock: req 0 sends 4 bytes while req 1 is valid throughout.
  - Required: no req 1 byte (and no 0x31 header) appears until req 0's last byte is accepted.
- Gap: GAP=16, two back-to-back 1-byte messages.
  - Required: exactly 16 cycles of tx_valid=0 after the first last handshake, plus 1 arbitration cycle, before the next header.
- Timeout: TIMEOUT=100, req 3 sends 1 byte without last, then drops valid.
  - Required: abort pulses exactly 100 cycles after the last handshake.
  - Then req 0 is granted next; req_ready[3] stays 0.
- Reset mid-BODY: assert rst low during a byte wait.
  - Required: tx_valid, req_ready and grant go 0 asynchronously.
  - After release, the first grant goes to the lowest valid index.
